// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one word read at a time, holds the returned
// instruction for decode, and redirects on branches while squashing stale data.
module instruction_fetch #(
  parameter int unsigned     s        = 32,
  parameter logic [s-1:0]    RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [s-1:0] branch_target,
  output logic         imem_req,
  output logic [s-1:0] imem_addr,
  input  logic         imem_valid,
  input  logic [s-1:0] imem_rdata,
  output logic [s-1:0] instruction,
  output logic         instr_valid,
  output logic [s-1:0] pc_out,
  output logic [s-1:0] pc_plus4
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } state_e;

  localparam logic [s-1:0] NOP_INSTR = s'(32'h0000_0013);
  localparam logic [s-1:0] PC_INC    = s'(32'd4);
  localparam logic [s-1:0] PC_START  = {RESET_PC[s-1:2], 2'b00};

  state_e       state_q, state_d;
  logic [s-1:0] pc_q, pc_d;
  logic [s-1:0] instruction_q, instruction_d;
  logic         instr_valid_q, instr_valid_d;
  logic [s-1:0] target_s;
  logic         unused_target_bits;

  // Redirect targets are always word aligned; the low bits are deliberately dropped.
  assign target_s           = {branch_target[s-1:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      FETCH: begin
        if (branch_taken) begin
          pc_d    = target_s;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_valid && branch_taken) begin
          pc_d    = target_s;
          state_d = FETCH;
        end else if (imem_valid) begin
          instruction_d = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end else if (branch_taken) begin
          pc_d    = target_s;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d          = target_s;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else if (!stall) begin
          pc_d          = pc_q + PC_INC;
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        // The stale response still has to drain before a new request may issue.
        if (branch_taken) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (imem_valid) begin
          state_d = FETCH;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d       = FETCH;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= PC_START;
      instruction_q <= NOP_INSTR;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + PC_INC;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch: one record per clock cycle
// giving the inputs for that cycle and the outputs expected during it.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  int passed = 0;
  int total  = 0;

  instruction_fetch #(.s(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        br;
    logic [31:0] tgt;
    logic        iv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        m_state;
    logic        m_instr;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input int id, input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL step%0d %s: got %h expected %h", id, name, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step(input int id, input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    stall         = v.stl;
    branch_taken  = v.br;
    branch_target = v.tgt;
    imem_valid    = v.iv;
    imem_rdata    = v.rd;
    #1;
    chk(id, "imem_req", {31'd0, imem_req}, {31'd0, v.e_req});
    if (v.e_req) chk(id, "imem_addr", imem_addr, v.e_addr);
    if (v.m_state) begin
      chk(id, "instr_valid", {31'd0, instr_valid}, {31'd0, v.e_iv});
      chk(id, "pc_out", pc_out, v.e_pc);
      chk(id, "pc_plus4", pc_plus4, v.e_pc + 32'd4);
    end
    if (v.m_instr) chk(id, "instruction", instruction, v.e_instr);
  endtask

  function automatic vec_t mk(input logic rst, stl, br, input logic [31:0] tgt,
                              input logic iv, input logic [31:0] rd,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic m_state, m_instr);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt; v.iv = iv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr;
    v.e_pc = e_pc; v.m_state = m_state; v.m_instr = m_instr;
    return v;
  endfunction

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0000_0000;
    imem_valid    = 1'b0;
    imem_rdata    = 32'h0000_0000;

    //            rst   stl   br    tgt            iv    rd             req   addr           iv    instr          pc             mS    mI
    vecs[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0013, 32'h0,         1'b1, 1'b1);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 1'b0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0050_0093, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0050_0093, 32'h0,         1'b1, 1'b1);
    vecs[5]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 32'h0050_0093, 32'h0,         1'b1, 1'b1);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0050_0093, 32'h0,         1'b1, 1'b1);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0050_0093, 32'h0,         1'b1, 1'b1);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h0,         32'h4,         1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h4,         1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         32'h100,       1'b1, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 32'h0,         32'h100,       1'b1, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h100,       1'b0, 32'h0,         32'h100,       1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h2222_2222, 1'b0, 32'h0,         1'b0, 32'h0,         32'h100,       1'b1, 1'b0);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h3333_3333, 1'b1, 32'h40,        1'b0, 32'h0,         32'h40,        1'b1, 1'b0);
    vecs[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h00A0_0113, 1'b0, 32'h0,         1'b0, 32'h0,         32'h40,        1'b1, 1'b0);
    vecs[16] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0203, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h00A0_0113, 32'h40,        1'b1, 1'b1);
    vecs[17] = mk(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0,         1'b1, 32'h200,       1'b0, 32'h0,         32'h200,       1'b1, 1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b1, 32'h0000_0404, 1'b1, 32'h4444_4444, 1'b0, 32'h0,         1'b0, 32'h0,         32'h300,       1'b1, 1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h404,       1'b0, 32'h0,         32'h404,       1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      step(i, vecs[i]);
    end

    // Reset while a request is outstanding; the late response lands in FETCH and is ignored.
    step(100, mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 32'h0,         32'h404, 1'b1, 1'b0));
    step(101, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555, 1'b1, 32'h0, 1'b0, 32'h0000_0013, 32'h0,   1'b1, 1'b1));
    step(102, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0070_0193, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b0));
    step(103, mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0070_0193, 32'h0,   1'b1, 1'b1));

    // Top-of-memory fetch: the sequential successor wraps to address zero.
    step(104, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0));
    step(105, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0513, 1'b0, 32'h0,         1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b0));
    step(106, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0513, 32'hFFFF_FFFC, 1'b1, 1'b1));
    step(107, mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0, 32'h0,         1'b1, 1'b0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
